// File: rtl/i2c_eeprom_slave_if.sv
// ---------------------------------------------------------------------------
// i2c_eeprom_slave_if
// Bundles the I2C clock line and the commit/status signals of the EEPROM
// target. SDA stays a plain inout pin on the target because it is an
// open-drain tristate net.
//
// Signals:
//   i2c_sclk  bus SCL from the master
//   busy      target is engaged in an addressed transaction
//   wr_pulse  one-clk strobe when a byte is committed to the array
//   wr_addr   address of the committed byte
//   wr_data   committed byte
// Modports: master (drives SCL, observes status), slave (the EEPROM target).
// ---------------------------------------------------------------------------
interface i2c_eeprom_slave_if #(
   parameter int ADDR_W = 8
);
   logic              i2c_sclk;
   logic              busy;
   logic              wr_pulse;
   logic [ADDR_W-1:0] wr_addr;
   logic [7:0]        wr_data;

   modport master (
      output i2c_sclk,
      input  busy,
      input  wr_pulse,
      input  wr_addr,
      input  wr_data
   );

   modport slave (
      input  i2c_sclk,
      output busy,
      output wr_pulse,
      output wr_addr,
      output wr_data
   );
endinterface

// File: rtl/i2c_eeprom_slave.sv
// ---------------------------------------------------------------------------
// i2c_eeprom_slave
// I2C target emulating a 24C02-class EEPROM: 7-bit device address, 8-bit word
// address, internal byte array. Supports byte/page write, current-address
// read, random read (repeated START) and sequential read.
//
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous active-high reset
//   bus       i2c_eeprom_slave_if.slave (SCL in, busy/wr_* out)
//   i2c_sdat  open-drain SDA: driven 0 or released, never driven 1
//
// state        | meaning
// -------------+---------------------------------------------------------
// S_IDLE       | bus free, waiting for START
// S_DEVADDR    | shifting in the control byte
// S_ACK_DEV    | acking the control byte
// S_WADDR      | shifting in the word address
// S_ACK_WADDR  | acking the word address
// S_WDATA      | shifting in a write data byte
// S_ACK_WDATA  | acking a write byte; commit on the ack-end SCL fall
// S_RDATA      | driving a read byte MSB first
// S_RACK       | sampling the master's ack/nack
// S_WAIT       | not addressed / done; ignore bits until START or STOP
// ---------------------------------------------------------------------------
module i2c_eeprom_slave #(
   parameter logic [6:0] DEV_ADDR = 7'h50,
   parameter int         ADDR_W   = 8,
   parameter int         PAGE_W   = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   i2c_eeprom_slave_if.slave    bus,
   inout  wire                  i2c_sdat
);

   typedef enum logic [3:0] {
      S_IDLE,
      S_DEVADDR,
      S_ACK_DEV,
      S_WADDR,
      S_ACK_WADDR,
      S_WDATA,
      S_ACK_WDATA,
      S_RDATA,
      S_RACK,
      S_WAIT
   } state_t;

   localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
   localparam logic [PAGE_W-1:0] PAGE_ONE = PAGE_W'(1);

   state_t            state_q;
   logic [3:0]        bit_cnt_q;
   logic [7:0]        shift_q;
   logic [ADDR_W-1:0] ptr_q;
   logic              rw_q;
   logic              sda_oe_q;
   logic              busy_q;
   logic              wr_pulse_q;
   logic [ADDR_W-1:0] wr_addr_q;
   logic [7:0]        wr_data_q;

   logic [7:0]        mem_q [0:(2**ADDR_W)-1];

   // 2-FF synchronizers plus a history stage per line; reset to the idle
   // bus level so leaving reset never fabricates an edge.
   logic [1:0]        scl_sync_q;
   logic [1:0]        sda_sync_q;
   logic              scl_hist_q;
   logic              sda_hist_q;

   logic              scl_s;
   logic              sda_s;
   logic              scl_rise;
   logic              scl_fall;
   logic              sda_rise;
   logic              sda_fall;
   logic              bus_start;
   logic              bus_stop;
   logic [7:0]        rd_byte;
   logic [ADDR_W-1:0] ptr_page_inc;
   logic              mem_we;

   always_ff @(posedge clk) begin
      if (rst) begin
         scl_sync_q <= 2'b11;
         sda_sync_q <= 2'b11;
         scl_hist_q <= 1'b1;
         sda_hist_q <= 1'b1;
      end else begin
         scl_sync_q <= {scl_sync_q[0], bus.i2c_sclk};
         sda_sync_q <= {sda_sync_q[0], i2c_sdat};
         scl_hist_q <= scl_sync_q[1];
         sda_hist_q <= sda_sync_q[1];
      end
   end

   assign scl_s     = scl_sync_q[1];
   assign sda_s     = sda_sync_q[1];
   assign scl_rise  =  scl_s & ~scl_hist_q;
   assign scl_fall  = ~scl_s &  scl_hist_q;
   assign sda_rise  =  sda_s & ~sda_hist_q;
   assign sda_fall  = ~sda_s &  sda_hist_q;
   assign bus_start = sda_fall & scl_s;
   assign bus_stop  = sda_rise & scl_s;

   assign rd_byte      = mem_q[ptr_q];
   // page write wraps only the low PAGE_W bits of the pointer
   assign ptr_page_inc = {ptr_q[ADDR_W-1:PAGE_W], ptr_q[PAGE_W-1:0] + PAGE_ONE};

   // Commit happens on the ack-end SCL fall; START/STOP in the same clk wins.
   assign mem_we = !rst && !bus_start && !bus_stop &&
                   (state_q == S_ACK_WDATA) && scl_fall;

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[ptr_q] <= shift_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         bit_cnt_q  <= 4'd0;
         shift_q    <= 8'h00;
         ptr_q      <= '0;
         rw_q       <= 1'b0;
         sda_oe_q   <= 1'b0;
         busy_q     <= 1'b0;
         wr_pulse_q <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= 8'h00;
      end else begin
         wr_pulse_q <= 1'b0;
         if (bus_start) begin
            // busy is kept across a repeated START; it rises on address match
            state_q   <= S_DEVADDR;
            bit_cnt_q <= 4'd0;
            sda_oe_q  <= 1'b0;
         end else if (bus_stop) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= 4'd0;
            sda_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
         end else begin
            case (state_q)
               S_DEVADDR, S_WADDR, S_WDATA: begin
                  if (scl_rise && bit_cnt_q != 4'd8) begin
                     shift_q   <= {shift_q[6:0], sda_s};
                     bit_cnt_q <= bit_cnt_q + 4'd1;
                  end else if (scl_fall && bit_cnt_q == 4'd8) begin
                     bit_cnt_q <= 4'd0;
                     if (state_q == S_DEVADDR) begin
                        if (shift_q[7:1] == DEV_ADDR) begin
                           rw_q     <= shift_q[0];
                           sda_oe_q <= 1'b1;
                           busy_q   <= 1'b1;
                           state_q  <= S_ACK_DEV;
                        end else begin
                           sda_oe_q <= 1'b0;
                           busy_q   <= 1'b0;
                           state_q  <= S_WAIT;
                        end
                     end else if (state_q == S_WADDR) begin
                        ptr_q    <= shift_q[ADDR_W-1:0];
                        sda_oe_q <= 1'b1;
                        state_q  <= S_ACK_WADDR;
                     end else begin
                        sda_oe_q <= 1'b1;
                        state_q  <= S_ACK_WDATA;
                     end
                  end
               end

               S_ACK_DEV: begin
                  if (scl_fall) begin
                     if (rw_q) begin
                        // first read bit is driven on the same fall that ends the ack
                        shift_q   <= rd_byte;
                        sda_oe_q  <= ~rd_byte[7];
                        bit_cnt_q <= 4'd1;
                        state_q   <= S_RDATA;
                     end else begin
                        sda_oe_q  <= 1'b0;
                        bit_cnt_q <= 4'd0;
                        state_q   <= S_WADDR;
                     end
                  end
               end

               S_ACK_WADDR: begin
                  if (scl_fall) begin
                     sda_oe_q  <= 1'b0;
                     bit_cnt_q <= 4'd0;
                     state_q   <= S_WDATA;
                  end
               end

               S_ACK_WDATA: begin
                  if (scl_fall) begin
                     wr_pulse_q <= 1'b1;
                     wr_addr_q  <= ptr_q;
                     wr_data_q  <= shift_q;
                     ptr_q      <= ptr_page_inc;
                     sda_oe_q   <= 1'b0;
                     bit_cnt_q  <= 4'd0;
                     state_q    <= S_WDATA;
                  end
               end

               S_RDATA: begin
                  // bit_cnt counts bits already placed on the bus
                  if (scl_fall) begin
                     if (bit_cnt_q == 4'd8) begin
                        sda_oe_q  <= 1'b0;
                        bit_cnt_q <= 4'd0;
                        state_q   <= S_RACK;
                     end else begin
                        shift_q   <= {shift_q[6:0], 1'b0};
                        sda_oe_q  <= ~shift_q[6];
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                     end
                  end
               end

               S_RACK: begin
                  // a NACK leaves on the rise, so any fall seen here follows an ACK
                  if (scl_rise) begin
                     ptr_q <= ptr_q + PTR_ONE;
                     if (sda_s) begin
                        busy_q  <= 1'b0;
                        state_q <= S_WAIT;
                     end
                  end else if (scl_fall) begin
                     shift_q   <= rd_byte;
                     sda_oe_q  <= ~rd_byte[7];
                     bit_cnt_q <= 4'd1;
                     state_q   <= S_RDATA;
                  end
               end

               S_IDLE, S_WAIT: begin
                  sda_oe_q <= 1'b0;
               end

               default: begin
                  state_q  <= S_IDLE;
                  sda_oe_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign i2c_sdat     = sda_oe_q ? 1'b0 : 1'bz;
   assign bus.busy     = busy_q;
   assign bus.wr_pulse = wr_pulse_q;
   assign bus.wr_addr  = wr_addr_q;
   assign bus.wr_data  = wr_data_q;

endmodule

// File: tb/tb_i2c_eeprom_slave.sv
// ---------------------------------------------------------------------------
// tb_i2c_eeprom_slave
// Directed bench for i2c_eeprom_slave: a bit-banged I2C master drives SCL/SDA
// with SCL quarter periods of Q system clocks; the SDA net has a pull-up.
// ---------------------------------------------------------------------------
module tb_i2c_eeprom_slave;
   localparam int ADDR_W = 8;
   localparam int Q      = 8;

   logic clk      = 1'b0;
   logic rst      = 1'b1;
   logic m_scl    = 1'b1;
   logic m_sda_oe = 1'b0;
   logic mon_en   = 1'b0;
   wire  sda;

   int n_checks = 0;
   int n_fail   = 0;
   int low_cnt  = 0;
   logic [ADDR_W+7:0] wr_log [$];

   i2c_eeprom_slave_if #(.ADDR_W(ADDR_W)) bus_if ();

   assign bus_if.i2c_sclk = m_scl;
   pullup (sda);
   assign sda = m_sda_oe ? 1'b0 : 1'bz;

   i2c_eeprom_slave #(
      .DEV_ADDR (7'h50),
      .ADDR_W   (ADDR_W),
      .PAGE_W   (3)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus_if.slave),
      .i2c_sdat (sda)
   );

   always #10 clk = ~clk;

   always @(negedge clk) begin
      if (bus_if.wr_pulse) wr_log.push_back({bus_if.wr_addr, bus_if.wr_data});
      if (mon_en && !m_sda_oe && sda == 1'b0) low_cnt <= low_cnt + 1;
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
   endtask

   task automatic i2c_start();
      m_sda_oe = 1'b0;
      wait_clk(Q);
      m_scl = 1'b1;
      wait_clk(Q);
      m_sda_oe = 1'b1;
      wait_clk(Q);
      m_scl = 1'b0;
      wait_clk(Q);
   endtask

   task automatic i2c_stop();
      m_sda_oe = 1'b1;
      wait_clk(Q);
      m_scl = 1'b1;
      wait_clk(Q);
      m_sda_oe = 1'b0;
      wait_clk(2 * Q);
   endtask

   task automatic clk_bit(input logic b, output logic rd);
      m_sda_oe = ~b;
      wait_clk(Q);
      m_scl = 1'b1;
      wait_clk(Q);
      rd = sda;
      wait_clk(Q);
      m_scl = 1'b0;
      wait_clk(Q);
   endtask

   task automatic send_byte(input logic [7:0] b, output logic ack);
      logic rd;
      for (int i = 7; i >= 0; i--) clk_bit(b[i], rd);
      clk_bit(1'b1, ack);
   endtask

   task automatic read_byte(input logic m_ack, output logic [7:0] d);
      logic rd;
      for (int i = 7; i >= 0; i--) begin
         clk_bit(1'b1, rd);
         d[i] = rd;
      end
      clk_bit(~m_ack, rd);
   endtask

   task automatic byte_write(input logic [7:0] addr, input logic [7:0] data);
      logic a0, a1, a2;
      int base;
      base = wr_log.size();
      i2c_start();
      send_byte(8'hA0, a0);
      send_byte(addr, a1);
      send_byte(data, a2);
      i2c_stop();
      check_val("bw_acks", {29'd0, a0, a1, a2}, 32'd0);
      check_val("bw_npulse", wr_log.size() - base, 32'd1);
      if (wr_log.size() > base)
         check_val("bw_commit", {16'd0, wr_log[base]}, {16'd0, addr, data});
   endtask

   task automatic rand_read(input logic [7:0] addr, output logic [7:0] d);
      logic a0, a1, a2;
      i2c_start();
      send_byte(8'hA0, a0);
      send_byte(addr, a1);
      i2c_start();
      send_byte(8'hA1, a2);
      read_byte(1'b0, d);
      i2c_stop();
      check_val("rr_acks", {29'd0, a0, a1, a2}, 32'd0);
   endtask

   initial begin
      logic a0, a1, a2, a3;
      logic [7:0] d0, d1;
      int base;
      int low_base;

      // reset state
      wait_clk(5);
      @(negedge clk);
      check_val("rst_busy", {31'd0, bus_if.busy}, 32'd0);
      check_val("rst_wr_pulse", {31'd0, bus_if.wr_pulse}, 32'd0);
      check_val("rst_wr_addr", {24'd0, bus_if.wr_addr}, 32'd0);
      check_val("rst_wr_data", {24'd0, bus_if.wr_data}, 32'd0);
      check_val("rst_sda", {31'd0, sda}, 32'd1);
      rst = 1'b0;
      wait_clk(4);

      // byte write 10 <= 5A
      base = wr_log.size();
      i2c_start();
      send_byte(8'hA0, a0);
      check_val("wr_busy_active", {31'd0, bus_if.busy}, 32'd1);
      send_byte(8'h10, a1);
      send_byte(8'h5A, a2);
      i2c_stop();
      check_val("wr_acks", {29'd0, a0, a1, a2}, 32'd0);
      check_val("wr_npulse", wr_log.size() - base, 32'd1);
      if (wr_log.size() > base)
         check_val("wr_commit", {16'd0, wr_log[base]}, 32'h0000_105A);
      check_val("wr_busy_after_stop", {31'd0, bus_if.busy}, 32'd0);

      // random read of 10
      i2c_start();
      send_byte(8'hA0, a0);
      send_byte(8'h10, a1);
      i2c_start();
      send_byte(8'hA1, a2);
      read_byte(1'b0, d0);
      check_val("rr_sda_released", {31'd0, sda}, 32'd1);
      i2c_stop();
      check_val("rr_acks", {29'd0, a0, a1, a2}, 32'd0);
      check_val("rr_data", {24'd0, d0}, 32'h5A);
      check_val("rr_ptr", {24'd0, dut.ptr_q}, 32'h11);

      // page write wrap 1E,1F,18,19
      base = wr_log.size();
      i2c_start();
      send_byte(8'hA0, a0);
      send_byte(8'h1E, a1);
      send_byte(8'h11, a2);
      send_byte(8'h22, a3);
      check_val("pg_acks_a", {28'd0, a0, a1, a2, a3}, 32'd0);
      send_byte(8'h33, a0);
      send_byte(8'h44, a1);
      i2c_stop();
      check_val("pg_acks_b", {30'd0, a0, a1}, 32'd0);
      check_val("pg_npulse", wr_log.size() - base, 32'd4);
      if (wr_log.size() >= base + 4) begin
         check_val("pg_w0", {16'd0, wr_log[base]},   32'h0000_1E11);
         check_val("pg_w1", {16'd0, wr_log[base+1]}, 32'h0000_1F22);
         check_val("pg_w2", {16'd0, wr_log[base+2]}, 32'h0000_1833);
         check_val("pg_w3", {16'd0, wr_log[base+3]}, 32'h0000_1944);
      end
      rand_read(8'h18, d0);
      check_val("pg_mem18", {24'd0, d0}, 32'h33);

      // sequential read across the top of the array
      byte_write(8'hFF, 8'hAB);
      byte_write(8'h00, 8'hCD);
      i2c_start();
      send_byte(8'hA0, a0);
      send_byte(8'hFF, a1);
      i2c_start();
      send_byte(8'hA1, a2);
      read_byte(1'b1, d0);
      read_byte(1'b0, d1);
      i2c_stop();
      check_val("sq_acks", {29'd0, a0, a1, a2}, 32'd0);
      check_val("sq_byte0", {24'd0, d0}, 32'hAB);
      check_val("sq_byte1", {24'd0, d1}, 32'hCD);

      // address mismatch
      base     = wr_log.size();
      low_base = low_cnt;
      mon_en   = 1'b1;
      i2c_start();
      send_byte(8'hA2, a0);
      send_byte(8'h10, a1);
      send_byte(8'h77, a2);
      i2c_stop();
      wait_clk(1);
      mon_en = 1'b0;
      check_val("mm_nacks", {29'd0, a0, a1, a2}, 32'd7);
      check_val("mm_sda_low_seen", low_cnt - low_base, 32'd0);
      check_val("mm_npulse", wr_log.size() - base, 32'd0);
      check_val("mm_busy", {31'd0, bus_if.busy}, 32'd0);
      rand_read(8'h10, d0);
      check_val("mm_mem10", {24'd0, d0}, 32'h5A);

      // reset while target drives a 0 data bit (mem[18]=33, bit7=0)
      i2c_start();
      send_byte(8'hA0, a0);
      send_byte(8'h18, a1);
      i2c_start();
      send_byte(8'hA1, a2);
      check_val("rs_acks", {29'd0, a0, a1, a2}, 32'd0);
      check_val("rs_target_low", {31'd0, sda}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_val("rs_sda_released", {31'd0, sda}, 32'd1);
      check_val("rs_busy", {31'd0, bus_if.busy}, 32'd0);
      byte_write(8'h20, 8'h99);
      rand_read(8'h20, d0);
      check_val("rs_mem20", {24'd0, d0}, 32'h99);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/i2c_eeprom_slave.md
Name: i2c_eeprom_slave

Overview:
- Synthesizable I2C target that emulates a 24C02-class serial EEPROM: 7-bit device address, 8-bit word address, internal byte array.
- Responder counterpart to the I2C EEPROM master controller. It sits behind the board I2C bus and serves as an on-chip EEPROM stand-in and self-test partner for the master.
- Supports byte write, page write, current-address read, random read (repeated START) and sequential read.

Parameters:
- DEV_ADDR, 7'h50, 7-bit target address; a matching control byte is 8'hA0 for write, 8'hA1 for read.
- ADDR_W, 8, word-address width; array depth is 2**ADDR_W.
- PAGE_W, 3, log2 of page size for write wrap (8-byte pages).

Ports:
- clk  input  1  system clock, 50 MHz; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- i2c_sclk  input  1  bus SCL from master (≤400 kHz).
- i2c_sdat  inout  1  bus SDA, open-drain: driven 0 or high-Z only, never 1.
- busy  output  1  high from addressed START until STOP or NACK/mismatch release.
- wr_pulse  output  1  one-clk strobe when a data byte is committed to the array.
- wr_addr  output  ADDR_W  address of the committed byte; valid with wr_pulse.
- wr_data  output  8  committed byte; valid with wr_pulse.

Behaviour:
- Input sampling:
  - SCL and SDA each pass through a 2-FF synchronizer plus a 1-FF history stage.
  - scl_rise, scl_fall, sda_rise and sda_fall are single-clk pulses.
- Bus conditions:
  - START = sda_fall while synced SCL high. STOP = sda_rise while synced SCL high.
  - START/STOP take priority over any bit event in the same clk.
  - Both are honoured in every state.
  - START gives state DEVADDR, bit count 0, SDA released. STOP gives IDLE, SDA released.
- Bit timing:
  - Bits are shifted MSB first and sampled on scl_rise.
  - SDA drive changes only on scl_fall, registered and taking effect within 2 clk of scl_fall.
- States: IDLE, DEVADDR, ACK_DEV, WADDR, ACK_WADDR, WDATA, ACK_WDATA, RDATA, RACK, WAIT.
- DEVADDR: after 8 bits (on the 8th scl_fall):
  - Upper 7 bits == DEV_ADDR: drive SDA low, go to ACK_DEV.
  - Otherwise: go to WAIT with SDA released and busy=0.
- ACK_DEV: on the next scl_fall, release SDA.
  - R/W=0: go to WADDR.
  - R/W=1: load mem[ptr], drive its bit7 (low if 0, release if 1), go to RDATA.
- WADDR: 8 bits go into ptr; ack as above (ACK_WADDR), then WDATA.
- WDATA: each byte is acked.
  - On the ack-end scl_fall: mem[ptr] <= byte, wr_pulse=1, wr_addr=ptr, wr_data=byte.
  - Then ptr low PAGE_W bits increment with wrap; upper bits are unchanged.
  - Stay in WDATA for further bytes.
- RDATA: each later scl_fall drives the next bit. After bit0's scl_fall, release SDA and go to RACK.
- RACK: sample the master's ack on scl_rise.
  - ACK (0): ptr <= ptr+1, wrapping the full array 2**ADDR_W-1 to 0. On scl_fall, load the next byte and go to RDATA.
  - NACK (1): ptr <= ptr+1, go to WAIT.
- WAIT: SDA released; ignore all bits until START or STOP.
- A repeated START after WADDR keeps ptr. This is how random read is done.
- Reset values: state IDLE, SDA released (oe=0), busy=0, wr_pulse=0, wr_addr=0, wr_data=0, ptr=0, bit count 0, shift register 0.
- Array contents are not cleared by reset.
- Reset mid-transaction: SDA is released on the clk after rst is sampled. The block ignores the bus until the next START.
- A partial write byte (STOP before the 8th bit plus ack) is discarded and wr_pulse is not asserted.
- sdat high-Z is read as 1 (external pull-up).

Test Plan:
- Byte write:
  - Stimulus: START, A0, 10, 5A, STOP.
  - Required: target ACK low on all three ack slots; single wr_pulse with wr_addr=8'h10, wr_data=8'h5A; busy 0 after STOP.
- Random read:
  - Stimulus: START, A0, 10, rSTART, A1, read 1 byte, master NACK, STOP.
  - Required: returned byte 8'h5A; SDA high-Z after the NACK; final ptr 8'h11.
- Page wrap:
  - Stimulus: START, A0, 1E, then 11, 22, 33, 44, STOP.
  - Required: wr_pulse addresses 1E, 1F, 18, 19 in order; 18 holds 8'h33.
- Sequential read wrap:
  - Stimulus: preload FF=8'hAB and 00=8'hCD; START, A0, FF, rSTART, A1, read 2 bytes with ACK then NACK.
  - Required: bytes AB then CD.
- Address mismatch:
  - Stimulus: START, A2, 10, 77, STOP.
  - Required: SDA never driven low by the target; no wr_pulse; array unchanged.
- Reset mid-read:
  - Stimulus: assert rst for 1 clk while the target drives a 0 data bit.
  - Required: SDA high-Z on the next clk; a following byte write to 8'h20 completes normally.
